// File: rtl/stage2_decode.sv
// ---------------------------------------------------------------------------
// stage2_decode : instruction-decode (ID) stage of the 10-bit pipeline.
//
// Decodes the instruction coming out of the IF register and reads its
// operands from a 4 x 10 register file. The register file is written by
// writeback and forwards a same-cycle write to the reader. The stage detects
// load-use hazards and resolves unconditional jumps. It squashes the
// wrong-path fetch that follows a taken jump, and registers the decoded
// fields into the ID/EX pipeline register.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   instruction_in    instruction from the IF register
//   pc_in             PC of instruction_in
//   wb_en/addr/data   register-file write port (writeback)
//   flush             branch taken in EX: kill ID contents
//   stall_in          downstream stall: freeze ID/EX
//   pc_en             to stage1 PC enable (0 = hold IF)
//   j_cntrl, la_id    jump taken in ID and its target
//   op_out .. pc_out  ID/EX register contents
//   mem_read_out      ID/EX holds a load
//   valid_out         ID/EX holds a real instruction
//   illegal           current instruction has an undefined opcode
// ---------------------------------------------------------------------------
module stage2_decode #(
  parameter int DW   = 10,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] instruction_in,
  input  logic [DW-1:0] pc_in,
  input  logic          wb_en,
  input  logic [1:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          flush,
  input  logic          stall_in,
  output logic          pc_en,
  output logic          j_cntrl,
  output logic [DW-1:0] la_id,
  output logic [3:0]    op_out,
  output logic [1:0]    rd_out,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic [DW-1:0] imm_out,
  output logic [DW-1:0] pc_out,
  output logic          mem_read_out,
  output logic          valid_out,
  output logic          illegal
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_ADDI = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_BEQZ = 4'd8,
    OP_J    = 4'd9,
    OP_LI   = 4'd10
  } opcode_e;

  typedef struct packed {
    logic          valid;
    logic          mem_read;
    logic [3:0]    op;
    logic [1:0]    rd;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
  } idex_t;

  // Instruction fields
  logic [3:0] f_op;
  logic [1:0] f_rd, f_rs, f_rt;
  logic [3:0] f_imm4;
  logic [5:0] f_imm6;

  assign f_op   = instruction_in[9:6];
  assign f_rd   = instruction_in[5:4];
  assign f_rs   = instruction_in[3:2];
  assign f_rt   = instruction_in[1:0];
  assign f_imm4 = instruction_in[3:0];
  assign f_imm6 = instruction_in[5:0];

  // State
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  idex_t         idex_q, idex_d;
  logic          squash_q, squash_d;

  // Decode results
  logic [3:0]    dec_op;
  logic [1:0]    dec_rd;
  logic          rd_a_en, rd_b_en;
  logic [1:0]    addr_a, addr_b;
  logic [DW-1:0] dec_imm;
  logic          dec_mem_read;
  logic          is_jump;
  logic          dec_illegal;
  logic [DW-1:0] rf_a, rf_b;
  logic          hazard;
  logic          jump_take;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    dec_op       = OP_NOP;
    dec_rd       = '0;
    rd_a_en      = 1'b0;
    rd_b_en      = 1'b0;
    addr_a       = f_rs;
    addr_b       = f_rt;
    dec_imm      = '0;
    dec_mem_read = 1'b0;
    is_jump      = 1'b0;
    dec_illegal  = 1'b0;
    case (f_op)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec_op  = f_op;
        dec_rd  = f_rd;
        rd_a_en = 1'b1;
        rd_b_en = 1'b1;
      end
      OP_ADDI: begin
        dec_op  = f_op;
        dec_rd  = f_rd;
        rd_a_en = 1'b1;
        addr_a  = f_rd;
        dec_imm = {{(DW-4){f_imm4[3]}}, f_imm4};
      end
      OP_LW: begin
        dec_op       = f_op;
        dec_rd       = f_rd;
        rd_a_en      = 1'b1;
        dec_mem_read = 1'b1;
      end
      OP_SW: begin
        // Store data comes from the rd field and travels on operand B.
        dec_op  = f_op;
        dec_rd  = f_rd;
        rd_a_en = 1'b1;
        rd_b_en = 1'b1;
        addr_b  = f_rd;
      end
      OP_BEQZ: begin
        dec_op  = f_op;
        dec_rd  = f_rd;
        rd_a_en = 1'b1;
        addr_a  = f_rd;
        dec_imm = {{(DW-4){f_imm4[3]}}, f_imm4};
      end
      OP_J: begin
        dec_op  = f_op;
        is_jump = 1'b1;
        dec_imm = {{(DW-6){f_imm6[5]}}, f_imm6};
      end
      OP_LI: begin
        dec_op  = f_op;
        dec_rd  = f_rd;
        dec_imm = {{(DW-4){1'b0}}, f_imm4};
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Register-file read ports with write-through bypass.
  always_comb begin
    rf_a = (wb_en && (wb_addr == addr_a)) ? wb_data : regs_q[addr_a];
    rf_b = (wb_en && (wb_addr == addr_b)) ? wb_data : regs_q[addr_b];
  end

  // A squashed instruction is a bubble, so it can neither stall nor jump.
  always_comb begin
    hazard = ~squash_q & idex_q.valid & idex_q.mem_read &
             ((rd_a_en & (addr_a == idex_q.rd)) |
              (rd_b_en & (addr_b == idex_q.rd)));
    jump_take = is_jump & ~squash_q & ~hazard & ~stall_in & ~flush;
  end

  assign la_id   = pc_in + DW'(1) + {{(DW-6){f_imm6[5]}}, f_imm6};
  assign j_cntrl = reset & jump_take;
  assign pc_en   = ~reset | ~(stall_in | hazard);
  assign illegal = dec_illegal;

  // ID/EX and squash next state, in priority order.
  always_comb begin
    idex_d   = idex_q;
    squash_d = squash_q;
    if (flush) begin
      idex_d   = '0;
      squash_d = 1'b0;
    end else if (!stall_in) begin
      // Not flushing or stalling: the flag marks exactly the fetch after a jump.
      squash_d = jump_take;
      if (hazard || squash_q) begin
        idex_d = '0;
      end else begin
        idex_d.valid    = 1'b1;
        idex_d.mem_read = dec_mem_read;
        idex_d.op       = dec_op;
        idex_d.rd       = dec_rd;
        idex_d.rs_data  = rd_a_en ? rf_a : '0;
        idex_d.rt_data  = rd_b_en ? rf_b : '0;
        idex_d.imm      = dec_imm;
        idex_d.pc       = pc_in;
      end
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en) regs_d[wb_addr] = wb_data;
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q   <= '0;
      squash_q <= 1'b0;
    end else begin
      idex_q   <= idex_d;
      squash_q <= squash_d;
    end
  end

  // NOTE: this register file is built from flops and must read as zero after
  // reset, so it is cleared explicitly. A RAM-style array would stay unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign valid_out    = idex_q.valid;
  assign mem_read_out = idex_q.mem_read;
  assign op_out       = idex_q.op;
  assign rd_out       = idex_q.rd;
  assign rs_data      = idex_q.rs_data;
  assign rt_data      = idex_q.rt_data;
  assign imm_out      = idex_q.imm;
  assign pc_out       = idex_q.pc;

endmodule

// File: tb/tb_stage2_decode.sv
// ---------------------------------------------------------------------------
// tb_stage2_decode : self-checking bench for stage2_decode.
// Each step drives one ID-stage cycle and checks the combinational outputs
// before the edge. It pushes the expected ID/EX contents to a scoreboard
// queue, then pops that entry and compares it with the registered outputs
// after the edge.
// ---------------------------------------------------------------------------
module tb_stage2_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] instruction_in, pc_in, wb_data;
  logic       wb_en, flush, stall_in;
  logic [1:0] wb_addr;
  logic       pc_en, j_cntrl, mem_read_out, valid_out, illegal;
  logic [9:0] la_id, rs_data, rt_data, imm_out, pc_out;
  logic [3:0] op_out;
  logic [1:0] rd_out;

  stage2_decode dut (
    .clk(clk), .reset(reset),
    .instruction_in(instruction_in), .pc_in(pc_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .stall_in(stall_in),
    .pc_en(pc_en), .j_cntrl(j_cntrl), .la_id(la_id),
    .op_out(op_out), .rd_out(rd_out), .rs_data(rs_data), .rt_data(rt_data),
    .imm_out(imm_out), .pc_out(pc_out), .mem_read_out(mem_read_out),
    .valid_out(valid_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // care bits: 0 rd, 1 rs_data, 2 rt_data, 3 imm, 4 pc
  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic [3:0] op;
    logic [1:0] rd;
    logic [9:0] rs, rt, imm, pc;
    logic [4:0] care;
  } exp_t;

  typedef struct packed {
    logic       pc_en;
    logic       j;
    logic       ill;
    logic [9:0] la;
  } comb_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_no  = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t bub();
    exp_t e;
    e      = '0;
    e.care = 5'b11111;
    return e;
  endfunction

  function automatic exp_t ins(input logic [3:0] op, input logic mr, input logic [9:0] pc,
                               input logic [4:0] care, input logic [1:0] rd,
                               input logic [9:0] rs, input logic [9:0] rt, input logic [9:0] imm);
    exp_t e;
    e.valid = 1'b1; e.mem_read = mr; e.op = op; e.rd = rd;
    e.rs = rs; e.rt = rt; e.imm = imm; e.pc = pc; e.care = care;
    return e;
  endfunction

  function automatic comb_t cb(input logic pe, input logic j, input logic ill, input logic [9:0] la);
    comb_t c;
    c.pc_en = pe; c.j = j; c.ill = ill; c.la = la;
    return c;
  endfunction

  task automatic compare_out();
    exp_t  e;
    string s;
    s = $sformatf("s%0d", step_no);
    if (sb_q.size() == 0) begin
      check({s, ".sb_empty"}, 16'(1), 16'(0));
    end else begin
      e = sb_q.pop_front();
      check({s, ".valid"},    16'(valid_out),    16'(e.valid));
      check({s, ".mem_read"}, 16'(mem_read_out), 16'(e.mem_read));
      check({s, ".op"},       16'(op_out),       16'(e.op));
      if (e.care[0]) check({s, ".rd"},      16'(rd_out),  16'(e.rd));
      if (e.care[1]) check({s, ".rs_data"}, 16'(rs_data), 16'(e.rs));
      if (e.care[2]) check({s, ".rt_data"}, 16'(rt_data), 16'(e.rt));
      if (e.care[3]) check({s, ".imm"},     16'(imm_out), 16'(e.imm));
      if (e.care[4]) check({s, ".pc"},      16'(pc_out),  16'(e.pc));
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic [9:0] instr, input logic [9:0] pc,
                      input logic fl, input logic st,
                      input logic we, input logic [1:0] wa, input logic [9:0] wd,
                      input comb_t c, input exp_t e);
    string s;
    step_no++;
    s = $sformatf("s%0d", step_no);
    instruction_in = instr; pc_in = pc; flush = fl; stall_in = st;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #3;
    check({s, ".pc_en"},   16'(pc_en),   16'(c.pc_en));
    check({s, ".j_cntrl"}, 16'(j_cntrl), 16'(c.j));
    check({s, ".illegal"}, 16'(illegal), 16'(c.ill));
    if (c.j) check({s, ".la_id"}, 16'(la_id), 16'(c.la));
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    compare_out();
  endtask

  task automatic check_reset_state(input string s);
    check({s, ".valid"},    16'(valid_out),    16'(0));
    check({s, ".op"},       16'(op_out),       16'(0));
    check({s, ".rd"},       16'(rd_out),       16'(0));
    check({s, ".rs_data"},  16'(rs_data),      16'(0));
    check({s, ".rt_data"},  16'(rt_data),      16'(0));
    check({s, ".imm"},      16'(imm_out),      16'(0));
    check({s, ".pc"},       16'(pc_out),       16'(0));
    check({s, ".mem_read"}, 16'(mem_read_out), 16'(0));
    check({s, ".pc_en"},    16'(pc_en),        16'(1));
    check({s, ".j_cntrl"},  16'(j_cntrl),      16'(0));
  endtask

  localparam logic [4:0] C_ALL = 5'b11111;
  localparam logic [4:0] C_PC  = 5'b10000;
  localparam logic [4:0] C_J   = 5'b11000;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset held for two cycles with a random J-class instruction and a stall.
    reset = 1'b0; flush = 1'b0; stall_in = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    instruction_in = {4'h9, 6'($urandom)};
    pc_in = 10'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    stall_in = 1'b0;
    reset = 1'b1;

    // Writeback r2, then ADD r1,r2,r3 with a simultaneous write of r3.
    step(10'h000, 10'h000, 0, 0, 1, 2'd2, 10'h155, cb(1, 0, 0, 0), ins(4'h0, 0, 10'h000, C_PC, 0, 0, 0, 0));
    step(10'h05B, 10'h001, 0, 0, 1, 2'd3, 10'h00A, cb(1, 0, 0, 0), ins(4'h1, 0, 10'h001, 5'b10111, 2'd1, 10'h155, 10'h00A, 0));
    // stall_in holds the ADD in ID/EX.
    step(10'h05B, 10'h001, 0, 1, 0, 2'd0, 10'h000, cb(0, 0, 0, 0), ins(4'h1, 0, 10'h001, 5'b10111, 2'd1, 10'h155, 10'h00A, 0));
    // LW r1,[r0] with r0 written in the same cycle, then dependent ADD r2,r1,r0.
    step(10'h190, 10'h002, 0, 0, 1, 2'd0, 10'h007, cb(1, 0, 0, 0), ins(4'h6, 1, 10'h002, 5'b10011, 2'd1, 10'h007, 0, 0));
    step(10'h064, 10'h003, 0, 0, 0, 2'd0, 10'h000, cb(0, 0, 0, 0), bub());
    step(10'h064, 10'h003, 0, 0, 0, 2'd0, 10'h000, cb(1, 0, 0, 0), ins(4'h1, 0, 10'h003, 5'b10111, 2'd2, 10'h000, 10'h007, 0));
    // LW r1 then independent ADD r2,r0,r3: no stall.
    step(10'h190, 10'h004, 0, 0, 0, 2'd0, 10'h000, cb(1, 0, 0, 0), ins(4'h6, 1, 10'h004, 5'b10011, 2'd1, 10'h007, 0, 0));
    step(10'h063, 10'h005, 0, 0, 0, 2'd0, 10'h000, cb(1, 0, 0, 0), ins(4'h1, 0, 10'h005, 5'b10111, 2'd2, 10'h007, 10'h00A, 0));
    // J -2 at 0x010, then a J in the shadow that must be squashed.
    step(10'h27E, 10'h010, 0, 0, 0, 2'd0, 10'h000, cb(1, 1, 0, 10'h00F), ins(4'h9, 0, 10'h010, C_J, 0, 0, 0, 10'h3FE));
    step(10'h27E, 10'h011, 0, 0, 0, 2'd0, 10'h000, cb(1, 0, 0, 0), bub());
    // J +1 at 0x3FF wraps to 0x001.
    step(10'h241, 10'h3FF, 0, 0, 0, 2'd0, 10'h000, cb(1, 1, 0, 10'h001), ins(4'h9, 0, 10'h3FF, C_J, 0, 0, 0, 10'h001));
    step(10'h000, 10'h000, 0, 0, 0, 2'd0, 10'h000, cb(1, 0, 0, 0), bub());
    // flush together with stall_in: bubble loaded and no jump.
    step(10'h27E, 10'h020, 1, 1, 0, 2'd0, 10'h000, cb(0, 0, 0, 0), bub());
    for (int i = 0; i < 3; i++)
      step(10'h27E, 10'h020, 0, 1, 0, 2'd0, 10'h000, cb(0, 0, 0, 0), bub());
    // Illegal opcode 0xC while writing r1.
    step(10'h300, 10'h030, 0, 0, 1, 2'd1, 10'h123, cb(1, 0, 1, 0), ins(4'h0, 0, 10'h030, C_PC, 0, 0, 0, 0));
    // ADDI r1,-3.
    step(10'h15D, 10'h031, 0, 0, 0, 2'd0, 10'h000, cb(1, 0, 0, 0), ins(4'h5, 0, 10'h031, 5'b11011, 2'd1, 10'h123, 0, 10'h3FD));
    // SW: address from r0, data from r3 on rt_data.
    step(10'h1F0, 10'h032, 0, 0, 0, 2'd0, 10'h000, cb(1, 0, 0, 0), ins(4'h7, 0, 10'h032, 5'b10111, 2'd3, 10'h007, 10'h00A, 0));
    // LW r3 then SW storing r3: hazard through the store-data read.
    step(10'h1B0, 10'h033, 0, 0, 0, 2'd0, 10'h000, cb(1, 0, 0, 0), ins(4'h6, 1, 10'h033, 5'b10011, 2'd3, 10'h007, 0, 0));
    step(10'h1F0, 10'h034, 0, 0, 0, 2'd0, 10'h000, cb(0, 0, 0, 0), bub());
    step(10'h1F0, 10'h034, 0, 0, 0, 2'd0, 10'h000, cb(1, 0, 0, 0), ins(4'h7, 0, 10'h034, 5'b10111, 2'd3, 10'h007, 10'h00A, 0));

    // Asynchronous reset mid-cycle, with a J and a stall present.
    instruction_in = 10'h27E; stall_in = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Register file is cleared: ADD r1,r2,r3 reads zeros; write r1 meanwhile.
    step(10'h05B, 10'h040, 0, 0, 1, 2'd1, 10'h2AA, cb(1, 0, 0, 0), ins(4'h1, 0, 10'h040, 5'b10111, 2'd1, 10'h000, 10'h000, 0));
    // BEQZ r1,-2 and LI r0,15.
    step(10'h21E, 10'h041, 0, 0, 0, 2'd0, 10'h000, cb(1, 0, 0, 0), ins(4'h8, 0, 10'h041, 5'b11011, 2'd1, 10'h2AA, 0, 10'h3FE));
    step(10'h28F, 10'h042, 0, 0, 0, 2'd0, 10'h000, cb(1, 0, 0, 0), ins(4'hA, 0, 10'h042, 5'b11001, 2'd0, 0, 0, 10'h00F));

    check("sb_drained", 16'(sb_q.size()), 16'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
